// File: rtl/mul_div_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings,
// op-field decode positions and the control FSM states.
package mul_div_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'b0000,
    OP_MUL    = 4'b0011,
    OP_MULH   = 4'b0101,
    OP_MULHSU = 4'b0110,
    OP_MULHU  = 4'b0111,
    OP_DIV    = 4'b1001,
    OP_DIVU   = 4'b1011,
    OP_REM    = 4'b1101,
    OP_REMU   = 4'b1111
  } mul_div_op_e;

  localparam int          OP_DIV_BIT  = 3;
  localparam int          OP_HI_BIT   = 2;
  localparam logic [1:0]  OP_UNSIGNED = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } mul_div_state_e;

  // rs1 is signed for everything except the fully unsigned encodings
  function automatic logic rs1_is_signed(input logic [3:0] op);
    return op[1:0] != OP_UNSIGNED;
  endfunction

  function automatic logic rs2_is_signed(input logic [3:0] op);
    return op[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/mul_div_datapath.sv
// Iteration registers for shift-add multiply and restoring divide, plus the
// divide special-case detection and final sign correction.
module mul_div_datapath
  import mul_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            load,
  input  logic            step,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            special,
  output logic [XLEN-1:0] special_result,
  output logic [XLEN-1:0] final_result
);

  localparam int W = 2 * XLEN;

  logic [W:0]      acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic            is_div_q, hi_q, neg_q;

  logic            a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shifted, diff;
  logic [W-1:0]    prod;
  logic [XLEN-1:0] rem_v, quo_v;

  always_comb begin
    a_neg = rs1_is_signed(op) && a[XLEN-1];
    b_neg = rs2_is_signed(op) && b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    div0  = (b == '0);
    ovf   = rs2_is_signed(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special = op[OP_DIV_BIT] && (div0 || ovf);
    // Overflow quotient equals the dividend itself, so both cases reuse a
    if (div0) special_result = op[OP_HI_BIT] ? a : '1;
    else      special_result = op[OP_HI_BIT] ? '0 : a;
  end

  always_comb begin
    shifted = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
    diff    = shifted - {1'b0, mcand_q[XLEN-1:0]};
    acc_d   = acc_q;
    mcand_d = mcand_q;
    opb_d   = opb_q;
    if (is_div_q) begin
      opb_d = {opb_q[XLEN-2:0], ~diff[XLEN]};
      acc_d = {{(W-XLEN){1'b0}}, diff[XLEN] ? shifted : diff};
    end else begin
      acc_d   = acc_q + (opb_q[0] ? {1'b0, mcand_q} : '0);
      mcand_d = mcand_q << 1;
      opb_d   = opb_q >> 1;
    end
    // Sign fix-up is applied to the post-step values so the last iteration
    // and result capture happen on the same edge
    prod  = neg_q ? -acc_d[W-1:0] : acc_d[W-1:0];
    rem_v = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    quo_v = neg_q ? -opb_d : opb_d;
    if (is_div_q) final_result = hi_q ? rem_v : quo_v;
    else          final_result = hi_q ? prod[W-1:XLEN] : prod[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= 1'b0;
      neg_q    <= 1'b0;
    end else if (load) begin
      is_div_q <= op[OP_DIV_BIT];
      hi_q     <= op[OP_HI_BIT];
      neg_q    <= (op[OP_DIV_BIT] && op[OP_HI_BIT]) ? a_neg : (a_neg ^ b_neg);
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, op[OP_DIV_BIT] ? b_mag : a_mag};
      opb_q    <= op[OP_DIV_BIT] ? a_mag : b_mag;
    end else if (step) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      opb_q   <= opb_d;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one operation in flight, control FSM
// with registered handshake and result outputs.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [TAG_W-1:0] rd_tag_in,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             result_valid,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_tag_out
);

  localparam int CNT_W = $clog2(XLEN);

  mul_div_state_e   state;
  logic [CNT_W-1:0] count;
  logic [TAG_W-1:0] tag_q;
  logic             accept, step, special;
  logic [XLEN-1:0]  special_result, final_result;

  assign accept = (state == S_IDLE) && start && (op != OP_NOP) && !flush;
  assign step   = (state == S_CALC) && !flush;

  mul_div_datapath #(.XLEN(XLEN)) u_datapath (
    .clk            (clk),
    .nrst           (nrst),
    .load           (accept),
    .step           (step),
    .op             (op),
    .a              (rs1_val),
    .b              (rs2_val),
    .special        (special),
    .special_result (special_result),
    .final_result   (final_result)
  );

  // Flush wins over completion: a flushed CALC returns to IDLE without a pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      count        <= '0;
      tag_q        <= '0;
      ready        <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      rd_tag_out   <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            tag_q <= rd_tag_in;
            ready <= 1'b0;
            busy  <= 1'b1;
            if (special) begin
              state        <= S_DONE;
              result       <= special_result;
              rd_tag_out   <= rd_tag_in;
              result_valid <= 1'b1;
            end else begin
              state <= S_CALC;
              count <= CNT_W'(XLEN - 1);
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else if (count == '0) begin
            state        <= S_DONE;
            result       <= final_result;
            rd_tag_out   <= tag_q;
            result_valid <= 1'b1;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors push expected results,
// an independent monitor pops and compares on every result_valid.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             nrst, start, flush;
  logic [3:0]       op;
  logic [XLEN-1:0]  rs1_val, rs2_val;
  logic [TAG_W-1:0] rd_tag_in;
  logic             ready, busy, result_valid;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] rd_tag_out;

  mul_div_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .start        (start),
    .op           (op),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .rd_tag_in    (rd_tag_in),
    .flush        (flush),
    .ready        (ready),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .rd_tag_out   (rd_tag_out)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge; the accept edge of an
  // operation is its cycle 0, and a value seen after edge N is "cycle N+1"
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  typedef struct {
    logic [3:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    bit               spec;
  } vec_t;

  exp_t sb[$];
  exp_t got;
  vec_t vecs[11];
  int   checks = 0;
  int   passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (nrst === 1'b1 && result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_result_valid", 32'(result_valid), 32'd0);
      end else begin
        got = sb.pop_front();
        checkOutput("result", result, got.res);
        checkOutput("rd_tag_out", 32'(rd_tag_out), 32'(got.tag));
        checkOutput("result_cycle", 32'(cyc), 32'(got.due));
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [TAG_W-1:0] t, input bit push, input logic [XLEN-1:0] res,
                               input bit spec);
    exp_t e;
    start     = 1'b1;
    op        = o;
    rs1_val   = a;
    rs2_val   = b;
    rd_tag_in = t;
    if (push) begin
      e.res = res;
      e.tag = t;
      e.due = cyc + 1 + (spec ? 0 : XLEN);
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op    = 4'b0000;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_returns", 32'(ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, required < 100000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd4,  1'b0};
    vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd5,  1'b0};
    vecs[2]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  1'b0};
    vecs[3]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 5'd7,  1'b0};
    vecs[4]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 5'd8,  1'b0};
    vecs[5]  = '{OP_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 5'd9,  1'b0};
    vecs[6]  = '{OP_REMU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 5'd10, 1'b0};
    vecs[7]  = '{OP_DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1};
    vecs[8]  = '{OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 5'd12, 1'b1};
    vecs[9]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd13, 1'b1};
    vecs[10] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 5'd14, 1'b1};

    nrst = 1'b0; start = 1'b0; flush = 1'b0; op = 4'b0000;
    rs1_val = '0; rs2_val = '0; rd_tag_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_result_valid", 32'(result_valid), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_rd_tag_out", 32'(rd_tag_out), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // op 0000 and start-with-flush must both leave the unit idle
    applyStimulus(4'b0000, 32'd1, 32'd2, 5'd1, 1'b0, '0, 1'b0);
    checkOutput("nop_ignored", 32'(ready), 32'd1);
    flush = 1'b1;
    applyStimulus(OP_MUL, 32'd3, 32'd4, 5'd2, 1'b0, '0, 1'b0);
    flush = 1'b0;
    checkOutput("flush_blocks_start", 32'(ready), 32'd1);

    // MUL with full latency and ready timing
    applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1, 32'hFFFF_FFEB, 1'b0);
    repeat (32) @(negedge clk);
    checkOutput("ready_low_in_done", 32'(ready), 32'd0);
    @(negedge clk);
    checkOutput("ready_back_cycle34", 32'(ready), 32'd1);
    checkOutput("busy_clear_cycle34", 32'(busy), 32'd0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1, vecs[i].res, vecs[i].spec);
      waitIdle();
    end

    // Flush a MUL in cycle 10, then issue DIVU 100/7 in cycle 11
    applyStimulus(OP_MUL, 32'd9, 32'd9, 5'd15, 1'b0, '0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_to_idle", 32'(ready), 32'd1);
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd16, 1'b1, 32'd14, 1'b0);
    waitIdle();

    // Second start while busy is dropped; reset mid-operation kills the DIV
    applyStimulus(OP_DIV, 32'd100, 32'd3, 5'd17, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(OP_REMU, 32'd55, 32'd4, 5'd18, 1'b0, '0, 1'b0);
    checkOutput("busy_while_second_start", 32'(busy), 32'd1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    checkOutput("async_reset_ready", 32'(ready), 32'd1);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_result_valid", 32'(result_valid), 32'd0);
    checkOutput("async_reset_result", result, 32'd0);
    checkOutput("async_reset_rd_tag_out", 32'(rd_tag_out), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("idle_after_reset", 32'(ready), 32'd1);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes `mulDiv_op` and operands for M-extension instructions issued from decode.
- Produces a 32-bit result for writeback through the "m output" path (fn = 010).
- One operation in flight. Radix-2 shift-add multiply and restoring divide, with fast paths for the divide special cases.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- TAG_W, 5, width of the destination-register tag carried through with the operation.

Ports:
- clk  input  1  clock.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  request valid; accepted only when ready=1 and op≠0000.
- op  input  4  mulDiv_op encoding: 0011 MUL, 0101 MULH, 0111 MULHU, 0110 MULHSU, 1001 DIV, 1011 DIVU, 1101 REM, 1111 REMU, 0000 no-op.
- rs1_val  input  XLEN  operand a (multiplicand / dividend).
- rs2_val  input  XLEN  operand b (multiplier / divisor).
- rd_tag_in  input  TAG_W  destination tag.
- flush  input  1  kill the in-flight operation (exception/branch flush).
- ready  output  1  unit idle, can accept.
- busy  output  1  operation in flight (≠ready).
- result_valid  output  1  one-cycle pulse, result valid.
- result  output  XLEN  result value.
- rd_tag_out  output  TAG_W  tag of the result.

Behaviour:
- Reset:
  - Asynchronous on nrst low, all state cleared.
  - Outputs: ready=1, busy=0, result_valid=0, result=0, rd_tag_out=0.
  - State goes to IDLE.
  - Reset mid-operation abandons the operation; no result is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - On start with op≠0 and flush=0, latch operands, op and tag.
  - A divide special case goes to DONE; everything else goes to CALC with count=XLEN-1.
  - start with op=0000 is ignored.
- CALC:
  - One iteration per cycle.
  - When count=0, go to DONE; otherwise decrement count.
- DONE:
  - result_valid=1 for exactly one cycle; result and rd_tag_out are registered.
  - Next state is IDLE.
  - result and rd_tag_out hold their value until the next DONE.
- Latency, with the accept edge as cycle 0:
  - Normal operations: result_valid in cycle XLEN+1 (33).
  - Special cases: result_valid in cycle 1.
  - Next accept possible in cycle XLEN+2 (34).
- start while busy is ignored (no queueing). Upstream must stall on ready=0.
- Multiply:
  - Operands are extended to 2·XLEN bits.
  - MUL/MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
  - The accumulator uses the magnitude of each signed operand; the product is negated at the end if the signs differ.
  - MUL returns the low half of the product; MULH, MULHSU and MULHU return the high half.
- Divide:
  - Operands are converted to magnitudes for DIV/REM.
  - Restoring division over XLEN iterations.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Division truncates toward zero.
- Divide special cases (fast path):
  - Divisor 0: quotient = all ones (0xFFFFFFFF) for DIV and DIVU; remainder = dividend for REM and REMU.
  - Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF, DIV/REM only): quotient = 0x80000000, remainder = 0.
- flush:
  - In CALC or DONE, go to IDLE on the next edge with result_valid forced to 0 that cycle.
  - In IDLE, flush blocks acceptance of a simultaneous start.
  - flush takes priority over completion.
- All arithmetic is unsigned on explicit 2·XLEN+1-bit internals; sign handling is explicit, with no implicit signed casts.

Decomposition:
- Shared package `mul_div_pkg`:
  - Enum `mul_div_op_e` with the 4-bit op codes listed above.
  - Decode helper constants: bit3 = divide, bit2 = high/remainder, bits[1:0]=11 means unsigned.
  - The decoder will adopt the same enum.
- One sub-module, `mul_div_datapath`:
  - Contains the shift/add/subtract iteration registers.
  - Controlled by the FSM in `mul_div_unit`.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD (-3), start at cycle 0 -> result_valid only in cycle 33, result=0xFFFFFFEB, rd_tag_out=tag in, ready=1 again cycle 34.
2. MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
4. DIV 5/0 -> 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5 at cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
5. Start MUL, assert flush in cycle 10 -> no result_valid ever; ready=1 in cycle 11; new DIVU 100/7 accepted in cycle 11 -> 14.
6. Start DIV, assert start again with another op in cycle 3 -> second op ignored; nrst low in cycle 5 -> ready=1, result_valid=0, result=0 immediately; no pulse after release.
